// File: rtl/down_counter_reload_pkg.sv
// Shared definitions for the down_counter_reload block.
//
// Contents:
//   mode_e  - underflow policy encodings driven on the MODE port
//   state_e - two-state control FSM encoding (run / halted one-shot)
package down_counter_reload_pkg;

  // Underflow policy. Encoding 3 is reserved and behaves as MODE_WRAP.
  typedef enum logic [1:0] {
    MODE_WRAP    = 2'd0,
    MODE_RELOAD  = 2'd1,
    MODE_ONESHOT = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  // Control state. StHalt is only reachable through a one-shot underflow.
  typedef enum logic [0:0] {
    StRun  = 1'b0,
    StHalt = 1'b1
  } state_e;

endpackage

// File: rtl/down_counter_reload_sub_bout.sv
// Parameterised WIDTH-bit decrementer with borrow output.
//
// The subtraction is done one bit wider than the operand with a zero MSB, so
// the extra bit of the result is the borrow. It is set exactly when I == 0.
//
// Ports:
//   I     in  [WIDTH-1:0]  operand
//   O     out [WIDTH-1:0]  I - 1, modulo 2^WIDTH
//   BOUT  out              borrow out of the subtraction
module down_counter_reload_sub_bout #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] O,
  output logic             BOUT
);

  logic [WIDTH:0] diff;

  always_comb begin
    diff = {1'b0, I} - (WIDTH+1)'(1);
    O    = diff[WIDTH-1:0];
    BOUT = diff[WIDTH];
  end

endmodule

// File: rtl/down_counter_reload.sv
// Loadable down-counter with borrow pulse and selectable underflow policy.
//
// Counts toward zero one step per enabled cycle. On underflow it pulses BOUT
// for one cycle and then wraps to all-ones, reloads the last loaded value, or
// halts at zero (one-shot) depending on MODE sampled at that edge.
//
// Ports:
//   CLK          in                rising-edge clock
//   ASYNCRESETN  in                asynchronous reset, active-low
//   CE           in                count enable
//   LOAD         in                synchronous load of D (wins over CE)
//   D            in  [WIDTH-1:0]   load value, also captured as reload value
//   MODE         in  [1:0]         underflow policy (see down_counter_reload_pkg)
//   O            out [WIDTH-1:0]   registered count
//   BOUT         out               registered borrow pulse
//   ZERO         out               combinational, O == 0
//   DONE         out               registered, high while halted
module down_counter_reload
  import down_counter_reload_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned INIT  = 0
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic             CE,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  input  logic [1:0]       MODE,
  output logic [WIDTH-1:0] O,
  output logic             BOUT,
  output logic             ZERO,
  output logic             DONE
);

  localparam logic [WIDTH-1:0] InitVal = WIDTH'(INIT);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] rld_q;
  logic             bout_q;
  state_e           state_q;

  logic [WIDTH-1:0] count_dec;
  logic             borrow;

  down_counter_reload_sub_bout #(
    .WIDTH (WIDTH)
  ) u_dec (
    .I    (count_q),
    .O    (count_dec),
    .BOUT (borrow)
  );

  // Single-process FSM and datapath: LOAD > CE > hold. BOUT defaults low so
  // it can only be a one-cycle pulse per underflow edge.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      count_q <= InitVal;
      rld_q   <= InitVal;
      bout_q  <= 1'b0;
      state_q <= StRun;
    end else if (LOAD) begin
      count_q <= D;
      rld_q   <= D;
      bout_q  <= 1'b0;
      state_q <= StRun;
    end else begin
      bout_q <= 1'b0;
      if (CE && (state_q == StRun)) begin
        if (!borrow) begin
          count_q <= count_dec;
        end else begin
          // Underflow: policy is decided by MODE at this edge only.
          bout_q <= 1'b1;
          case (mode_e'(MODE))
            MODE_RELOAD: begin
              count_q <= rld_q;
            end
            MODE_ONESHOT: begin
              count_q <= '0;
              state_q <= StHalt;
            end
            default: begin
              count_q <= '1;
            end
          endcase
        end
      end
    end
  end

  assign O    = count_q;
  assign BOUT = bout_q;
  assign ZERO = (count_q == '0);
  assign DONE = (state_q == StHalt);

endmodule
